// File: rtl/conv_col_writer_if.sv
// Column-stream and memory-write bus of conv_col_writer.
// master drives columns and mem_ready; slave (the writer) answers with col_ready and writes.
interface conv_col_writer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_COLS   = 24,
  parameter int WORD_WIDTH = 256,
  parameter int ADDR_WIDTH = 12
);
  localparam int CNUM_W = $clog2(28) + 1;

  logic                  col_valid;
  logic [CNUM_W-1:0]     col_num;
  logic [DATA_WIDTH-1:0] col_data [OUT_COLS-1:0];
  logic                  col_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;

  modport master (
    output col_valid, col_num, col_data, mem_ready,
    input  col_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  col_valid, col_num, col_data, mem_ready,
    output col_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/conv_col_writer.sv
// Buffers conv output columns in a 2-deep FIFO and writes each one as two
// memory words (elements 0..15, then 16..OUT_COLS-1) at BASE_ADDR + 2*col_num.
module conv_col_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic                  sel_hi,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] lane
);
  assign lane = en ? (sel_hi ? hi : lo) : '0;
endmodule

module conv_col_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_COLS   = 24,
  parameter int NUM_COLS   = 24,
  parameter int WORD_WIDTH = 256,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  conv_col_writer_if.slave   bus,
  output logic               done,
  output logic               overflow,
  output logic               error,
  output logic               busy
);
  localparam int CNUM_W  = $clog2(28) + 1;
  localparam int LANES   = WORD_WIDTH / DATA_WIDTH;
  localparam int HI_BASE = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [CNUM_W-1:0]     num_q  [1:0];
  logic [DATA_WIDTH-1:0] data_q [1:0][OUT_COLS-1:0];
  logic [DATA_WIDTH-1:0] head_data [OUT_COLS-1:0];
  logic [CNUM_W-1:0]     head_num;
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            cnt, cnt_nxt;
  logic                  ready_q;
  logic                  active, in_range, push, pop, accept, clr, is_hi;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;

  assign active   = (state == S_WAIT) || (state == S_WR_LO) || (state == S_WR_HI);
  assign in_range = bus.col_num < CNUM_W'(NUM_COLS);
  assign push     = active && bus.col_valid && ready_q && in_range;
  assign accept   = bus.mem_we && bus.mem_ready;
  assign pop      = accept && (state == S_WR_HI);
  assign clr      = (state == S_IDLE) && start;
  assign is_hi    = (state == S_WR_HI);
  assign cnt_nxt  = clr ? 2'd0 : cnt + 2'(push) - 2'(pop);

  // WAIT/WR_HI look at next occupancy so a column pushed this cycle is
  // written starting next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WAIT;
      S_WAIT:  if (cnt_nxt != 2'd0) state_nxt = S_WR_LO;
      S_WR_LO: if (accept) state_nxt = S_WR_HI;
      S_WR_HI: if (accept) begin
        if (head_num == CNUM_W'(NUM_COLS - 1)) state_nxt = S_FIN;
        else if (cnt_nxt != 2'd0)              state_nxt = S_WR_LO;
        else                                   state_nxt = S_WAIT;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      ready_q  <= 1'b0;
      overflow <= 1'b0;
      error    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt < 2'd2);
      if (clr) begin
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        overflow <= 1'b0;
        error    <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        if (active && bus.col_valid && !ready_q)  overflow <= 1'b1;
        if (active && bus.col_valid && !in_range) error    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      num_q[wr_ptr]  <= bus.col_num;
      data_q[wr_ptr] <= bus.col_data;
    end
  end

  always_comb begin
    head_data = data_q[rd_ptr];
    head_num  = num_q[rd_ptr];
  end

  // {col_num, is_hi} is 2*col_num + is_hi; the sum wraps at ADDR_WIDTH bits.
  assign addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({head_num, is_hi});

  genvar j;
  generate
    for (j = 0; j < LANES; j++) begin : g_lane
      logic [DATA_WIDTH-1:0] lo_e, hi_e;
      if (j < OUT_COLS) begin : g_lo
        assign lo_e = head_data[j];
      end else begin : g_lo0
        assign lo_e = '0;
      end
      if (j + HI_BASE < OUT_COLS) begin : g_hi
        assign hi_e = head_data[j + HI_BASE];
      end else begin : g_hi0
        assign hi_e = '0;
      end
      conv_col_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .lo     (lo_e),
        .hi     (hi_e),
        .sel_hi (is_hi),
        .en     (bus.mem_we),
        .lane   (wdata[j*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  assign bus.mem_we    = (state == S_WR_LO) || (state == S_WR_HI);
  assign bus.mem_addr  = bus.mem_we ? addr : '0;
  assign bus.mem_wdata = wdata;
  assign bus.col_ready = ready_q;
  assign done          = (state == S_FIN);
  assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_conv_col_writer.sv
// Directed bench for conv_col_writer: reset, single column, full image,
// backpressure/overflow, range error and reset mid-write.
module tb_conv_col_writer;
  logic clk, rst, start;
  logic done, overflow, error, busy;

  conv_col_writer_if #(.DATA_WIDTH(16), .OUT_COLS(24), .WORD_WIDTH(256), .ADDR_WIDTH(12)) bus ();

  conv_col_writer #(
    .DATA_WIDTH(16), .OUT_COLS(24), .NUM_COLS(24),
    .WORD_WIDTH(256), .ADDR_WIDTH(12), .BASE_ADDR(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .done     (done),
    .overflow (overflow),
    .error    (error),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [11:0]  wr_addr [$];
  logic [255:0] wr_data [$];
  int           done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Writes are recorded half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ready) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (done) done_cnt++;
  end

  function automatic logic [255:0] exp_word(input logic [15:0] base, input bit hi);
    logic [255:0] w;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      int idx;
      idx = hi ? j + 16 : j;
      if (idx < 24) w[j*16 +: 16] = base + 16'(idx);
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_col(input logic [5:0] num, input logic [15:0] base);
    bus.col_valid = 1'b1;
    bus.col_num   = num;
    for (int k = 0; k < 24; k++) bus.col_data[k] = base + 16'(k);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.col_valid = 1'b0;
    bus.col_num = '0;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 24; k++) bus.col_data[k] = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.col_valid = 1'b0;
    bus.col_num = '0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 24; k++) bus.col_data[k] = '0;
    #2;
    n_chk++; if (bus.col_ready !== 1'b0) begin n_fail++; $display("FAIL reset_col_ready: got %b expected 0", bus.col_ready); end
    n_chk++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    n_chk++; if (bus.mem_addr !== 12'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); end
    n_chk++; if (bus.mem_wdata !== 256'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h expected 0", bus.mem_wdata); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    step();
    rst = 1'b1;
    step();
    n_chk++; if (bus.col_ready !== 1'b1) begin n_fail++; $display("FAIL release_col_ready: got %b expected 1", bus.col_ready); end
  endtask

  task automatic test_single();
    do_reset();
    bus.mem_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    set_col(6'd3, 16'h3C00);
    step();
    bus.col_valid = 1'b0;
    n_chk++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL single_lo_we: got %b expected 1", bus.mem_we); end
    n_chk++; if (bus.mem_addr !== 12'd6) begin n_fail++; $display("FAIL single_lo_addr: got %0d expected 6", bus.mem_addr); end
    n_chk++; if (bus.mem_wdata !== exp_word(16'h3C00, 1'b0)) begin n_fail++; $display("FAIL single_lo_data: got %h expected %h", bus.mem_wdata, exp_word(16'h3C00, 1'b0)); end
    step();
    n_chk++; if (bus.mem_addr !== 12'd7) begin n_fail++; $display("FAIL single_hi_addr: got %0d expected 7", bus.mem_addr); end
    n_chk++; if (bus.mem_wdata !== exp_word(16'h3C00, 1'b1)) begin n_fail++; $display("FAIL single_hi_data: got %h expected %h", bus.mem_wdata, exp_word(16'h3C00, 1'b1)); end
    step();
    n_chk++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL single_after_we: got %b expected 0", bus.mem_we); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_not_last_done: got %b expected 0", done); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_busy: got %b expected 1", busy); end
  endtask

  task automatic test_full_image();
    int b, db, n;
    do_reset();
    bus.mem_ready = 1'b1;
    b = wr_addr.size();
    db = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      set_col(6'(c), 16'h1000 + 16'(c * 32));
      step();
      bus.col_valid = 1'b0;
      step();
    end
    repeat (6) step();
    n = wr_addr.size() - b;
    n_chk++; if (n !== 48) begin n_fail++; $display("FAIL full_write_count: got %0d expected 48", n); end
    for (int i = 0; i < 48 && i < n; i++) begin
      n_chk++;
      if (wr_addr[b+i] !== 12'(i) || wr_data[b+i] !== exp_word(16'h1000 + 16'((i / 2) * 32), i[0])) begin
        n_fail++;
        $display("FAIL full_write_%0d: got addr %0d data %h expected addr %0d data %h", i, wr_addr[b+i], wr_data[b+i], i, exp_word(16'h1000 + 16'((i / 2) * 32), i[0]));
      end
    end
    n_chk++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt - db); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow: got %b expected 0", overflow); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int b, n;
    logic [11:0]  ea [4];
    logic [255:0] ed [4];
    do_reset();
    b = wr_addr.size();
    start = 1'b1;
    step();
    start = 1'b0;
    set_col(6'd5, 16'h5000);
    step();
    set_col(6'd6, 16'h6000);
    n_chk++; if (bus.mem_addr !== 12'd10 || bus.mem_wdata !== exp_word(16'h5000, 1'b0)) begin n_fail++; $display("FAIL bp_first_lo: got addr %0d data %h expected addr 10", bus.mem_addr, bus.mem_wdata); end
    step();
    set_col(6'd7, 16'h7000);
    n_chk++; if (bus.col_ready !== 1'b0) begin n_fail++; $display("FAIL bp_col_ready: got %b expected 0", bus.col_ready); end
    step();
    bus.col_valid = 1'b0;
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 12'd10 || bus.mem_wdata !== exp_word(16'h5000, 1'b0)) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got we %b addr %0d data %h expected we 1 addr 10", i, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
    end
    n_chk++; if (bus.col_ready !== 1'b0) begin n_fail++; $display("FAIL bp_col_ready_held: got %b expected 0", bus.col_ready); end
    bus.mem_ready = 1'b1;
    repeat (8) step();
    ea = '{12'd10, 12'd11, 12'd12, 12'd13};
    ed = '{exp_word(16'h5000, 1'b0), exp_word(16'h5000, 1'b1), exp_word(16'h6000, 1'b0), exp_word(16'h6000, 1'b1)};
    n = wr_addr.size() - b;
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL bp_write_count: got %0d expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_chk++;
      if (wr_addr[b+i] !== ea[i] || wr_data[b+i] !== ed[i]) begin
        n_fail++;
        $display("FAIL bp_write_%0d: got addr %0d data %h expected addr %0d data %h", i, wr_addr[b+i], wr_data[b+i], ea[i], ed[i]);
      end
    end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_range_error();
    int b, n;
    do_reset();
    bus.mem_ready = 1'b1;
    b = wr_addr.size();
    set_col(6'd2, 16'h2000);
    step();
    bus.col_valid = 1'b0;
    step();
    n_chk++; if (error !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_flags: got err %b ovf %b busy %b expected 0 0 0", error, overflow, busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    set_col(6'd24, 16'h2400);
    step();
    bus.col_valid = 1'b0;
    n_chk++; if (error !== 1'b1) begin n_fail++; $display("FAIL range_error: got %b expected 1", error); end
    repeat (4) step();
    n = wr_addr.size() - b;
    n_chk++; if (n !== 0) begin n_fail++; $display("FAIL range_no_write: got %0d writes expected 0", n); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_chk++; if (error !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_ignored_busy: got err %b busy %b expected 1 1", error, busy); end
    set_col(6'd23, 16'h2300);
    step();
    bus.col_valid = 1'b0;
    repeat (4) step();
    n = wr_addr.size() - b;
    n_chk++; if (n !== 2 || (n >= 1 && wr_addr[b] !== 12'd46)) begin n_fail++; $display("FAIL last_col_writes: got %0d writes expected 2 starting at addr 46", n); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL last_col_idle: got busy %b expected 0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_chk++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL start_clears_error: got err %b busy %b expected 0 1", error, busy); end
  endtask

  task automatic test_reset_mid();
    int b, n;
    do_reset();
    bus.mem_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    set_col(6'd0, 16'hB000);
    step();
    bus.col_valid = 1'b0;
    step();
    n_chk++; if (bus.mem_addr !== 12'd1) begin n_fail++; $display("FAIL mid_in_hi: got addr %0d expected 1", bus.mem_addr); end
    rst = 1'b0;
    #1;
    b = wr_addr.size();
    n_chk++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 12'd0 || bus.mem_wdata !== 256'd0) begin n_fail++; $display("FAIL mid_rst_bus: got we %b addr %0d data %h expected all 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || bus.col_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctl: got busy %b done %b ready %b expected 0 0 0", busy, done, bus.col_ready); end
    step();
    step();
    rst = 1'b1;
    repeat (4) step();
    n = wr_addr.size() - b;
    n_chk++; if (n !== 0) begin n_fail++; $display("FAIL mid_no_write_after_rst: got %0d writes expected 0", n); end
    start = 1'b1;
    step();
    start = 1'b0;
    set_col(6'd0, 16'hC000);
    step();
    bus.col_valid = 1'b0;
    repeat (4) step();
    n = wr_addr.size() - b;
    n_chk++; if (n !== 2) begin n_fail++; $display("FAIL mid_rearm_count: got %0d expected 2", n); end
    if (n >= 2) begin
      n_chk++; if (wr_addr[b] !== 12'd0 || wr_data[b] !== exp_word(16'hC000, 1'b0)) begin n_fail++; $display("FAIL mid_rearm_lo: got addr %0d data %h", wr_addr[b], wr_data[b]); end
      n_chk++; if (wr_addr[b+1] !== 12'd1 || wr_data[b+1] !== exp_word(16'hC000, 1'b1)) begin n_fail++; $display("FAIL mid_rearm_hi: got addr %0d data %h", wr_addr[b+1], wr_data[b+1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_image();
    test_backpressure();
    test_range_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_col_writer.md
CONV_COL_WRITER -- requirements
Module: conv_col_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FP16 element width.
REQ-002 SHALL have parameter OUT_COLS, default 24, elements per output column.
REQ-003 SHALL have parameter NUM_COLS, default 24, columns per image.
REQ-004 SHALL have parameters WORD_WIDTH (256), ADDR_WIDTH (12) and BASE_ADDR (0): memory word width, address width, first write address.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: arms the block for one image.
REQ-008 SHALL have port col_valid, input, 1: column present on col_num/col_data this cycle.
REQ-009 SHALL have port col_num, input, $clog2(28)+1 bits: column index.
REQ-010 SHALL have port col_data, input, DATA_WIDTH x [OUT_COLS-1:0] unpacked array: column elements.
REQ-011 SHALL have port col_ready, output, 1: high when fewer than 2 columns are buffered.
REQ-012 SHALL have port mem_we, output, 1: write request.
REQ-013 SHALL have ports mem_addr (output, ADDR_WIDTH) and mem_wdata (output, WORD_WIDTH): write address and write data.
REQ-014 SHALL have port mem_ready, input, 1: a write is accepted in any cycle where mem_we && mem_ready.
REQ-015 SHALL have ports done, overflow, error and busy, each output, 1 bit.

Function
REQ-016 SHALL implement the states IDLE, WAIT, WR_LO, WR_HI and FIN.
REQ-017 State transitions SHALL be:
- IDLE -> WAIT on start; WAIT -> WR_LO when the FIFO is non-empty.
- WR_LO -> WR_HI on lo-word acceptance.
- WR_HI on hi-word acceptance: -> FIN if the column written was NUM_COLS-1; else -> WR_LO if the FIFO still holds a column; else -> WAIT.
- FIN -> IDLE after one cycle.
REQ-018 SHALL buffer columns in a 2-entry FIFO.
- Push when col_valid && col_ready in state WAIT, WR_LO or WR_HI.
- Pop on hi-word acceptance; a simultaneous push and pop both take effect.
REQ-019 col_ready SHALL be derived from registered occupancy only, with no combinational path from mem_ready.
REQ-020 col_valid while col_ready is low SHALL drop the column and set overflow (sticky).
REQ-021 col_valid with col_num >= NUM_COLS SHALL drop the column and set error (sticky).
REQ-022 col_valid in IDLE or FIN SHALL be ignored, with no flag set.
REQ-023 The lo word SHALL be written as follows:
- mem_addr = BASE_ADDR + 2*col_num.
- mem_wdata lane j (bits j*DATA_WIDTH +: DATA_WIDTH) = element j, for j = 0..15.
REQ-024 The hi word SHALL be written as follows:
- mem_addr = BASE_ADDR + 2*col_num + 1.
- lanes 0..OUT_COLS-17 = elements 16..OUT_COLS-1; remaining lanes = 0.
REQ-025 mem_we SHALL be high exactly in WR_LO and WR_HI, and mem_addr/mem_wdata SHALL be held stable while mem_we && !mem_ready.
REQ-026 Columns SHALL be written in arrival order, unmodified; no arithmetic is applied to the data.
REQ-027 mem_addr SHALL be truncated to ADDR_WIDTH bits on overflow of the address sum (wrap-around).
REQ-028 Latency: column accepted in WAIT at cycle N with mem_ready=1 -> lo write at N+1, hi write at N+2; done at N+3 if it is the last column.
REQ-029 done SHALL be a one-cycle pulse asserted in FIN.
REQ-030 busy SHALL be high in every state except IDLE.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 start in IDLE SHALL clear overflow, error and the FIFO.

Reset
REQ-033 On rst low, state SHALL be IDLE and the FIFO empty, asynchronously.
REQ-034 On rst low, col_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, overflow=0, error=0 and busy=0.
REQ-035 rst asserted mid-write SHALL abandon the write; no further mem_we until re-armed by start.
REQ-036 Release of rst SHALL take effect on the next rising clk edge.

Verification
REQ-037 Bench SHALL cover single column: start; col_num=3, element k=16'h3C00+k; mem_ready=1 -> (addr 6, lanes 0..15 = 3C00..3C0F) then (addr 7, lanes 0..7 = 3C10..3C17, upper lanes 0).
REQ-038 Bench SHALL cover full image: columns 0..23 every 2 cycles, mem_ready=1 -> 48 writes to addr 0..47 in order, one done pulse, overflow=0.
REQ-039 Bench SHALL cover backpressure: mem_ready=0 for 10 cycles during the lo write -> addr/data held; 2 columns buffered; col_ready=0.
- A third col_valid in that window -> overflow=1 and that column is never written.
REQ-040 Bench SHALL cover range error: col_num=24 -> error=1 and no mem_we.
REQ-041 Bench SHALL cover reset mid-operation: rst low during WR_HI -> all outputs 0 immediately; start after release -> normal write of a new column 0 to addr 0/1.
